// File: rtl/pulse_period_sequencer_pkg.sv
// Shared types for the pulse/period timing sequencer: FSM state encoding and default widths.
package pop_timing_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH      = 16;
    localparam int DEFAULT_NPER_WIDTH = 16;

endpackage

// File: rtl/pulse_period_sequencer_if.sv
// Counter, control and status bundle between the sequencer and its surroundings.
interface pulse_period_sequencer_if #(
    parameter int WIDTH      = 16,
    parameter int NPER_WIDTH = 16
);

    logic [WIDTH-1:0]      count;
    logic                  ctr_reset;
    logic                  start;
    logic                  abort;
    logic [WIDTH-1:0]      period_val;
    logic [WIDTH-1:0]      on_start;
    logic [WIDTH-1:0]      on_stop;
    logic [NPER_WIDTH-1:0] n_periods;
    logic                  pulse_out;
    logic                  busy;
    logic                  done;
    logic [NPER_WIDTH-1:0] period_idx;

    modport master (
        output count, start, abort, period_val, on_start, on_stop, n_periods,
        input  ctr_reset, pulse_out, busy, done, period_idx
    );

    modport slave (
        input  count, start, abort, period_val, on_start, on_stop, n_periods,
        output ctr_reset, pulse_out, busy, done, period_idx
    );

endinterface

// File: rtl/pulse_period_sequencer_window_cmp.sv
// Registered pulse-window compare: the pulse is high one cycle after count lies in [on_start, on_stop).
module pulse_window_cmp #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] on_start,
    input  logic [WIDTH-1:0] on_stop,
    input  logic             en,
    output logic             pulse_out
);

    logic pulse_p1;

    // An empty or inverted window (on_start >= on_stop) can never satisfy both bounds.
    function automatic logic in_window(input logic [WIDTH-1:0] c,
                                       input logic [WIDTH-1:0] lo,
                                       input logic [WIDTH-1:0] hi);
        return (c >= lo) && (c < hi);
    endfunction

    // Stage p0 -> p1: compare against the live count and register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_p1 <= 1'b0;
        end else begin
            pulse_p1 <= en && in_window(count, on_start, on_stop);
        end
    end

    assign pulse_out = pulse_p1;

endmodule

// File: rtl/pulse_period_sequencer.sv
// Drives the upstream counter's reset to frame each period, repeats for n_periods, and gates the pulse window.
module pulse_period_sequencer #(
    parameter int WIDTH      = 16,
    parameter int NPER_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    pulse_period_sequencer_if.slave  bus
);

    import pop_timing_pkg::*;

    localparam logic [NPER_WIDTH-1:0] NPER_ONE = {{(NPER_WIDTH-1){1'b0}}, 1'b1};

    state_t                state;
    state_t                next_state;
    logic [WIDTH-1:0]      period_q;
    logic [WIDTH-1:0]      on_start_q;
    logic [WIDTH-1:0]      on_stop_q;
    logic [NPER_WIDTH-1:0] n_q;
    logic [NPER_WIDTH-1:0] period_idx_q;
    logic                  done_q;
    logic                  wrap;
    logic                  last_period;
    logic                  load;
    logic                  advance;
    logic                  pulse_en;
    logic                  ctr_reset;
    logic                  busy;

    assign wrap        = (state == RUN) && (bus.count == period_q);
    assign last_period = (n_q != '0) && (period_idx_q == (n_q - NPER_ONE));

    always_comb begin
        next_state = state;
        load       = 1'b0;
        advance    = 1'b0;
        pulse_en   = 1'b0;
        ctr_reset  = 1'b1;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    next_state = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                busy      = 1'b1;
                ctr_reset = (bus.count == period_q);
                // abort outranks wrap; the final wrap clears the pulse on the DONE-entry edge.
                if (bus.abort) begin
                    next_state = IDLE;
                end else if (wrap && last_period) begin
                    next_state = DONE;
                end else begin
                    pulse_en = 1'b1;
                    advance  = wrap;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            done_q       <= 1'b0;
            period_q     <= '0;
            on_start_q   <= '0;
            on_stop_q    <= '0;
            n_q          <= '0;
            period_idx_q <= '0;
        end else begin
            state  <= next_state;
            done_q <= (next_state == DONE);
            if (load) begin
                period_q     <= bus.period_val;
                on_start_q   <= bus.on_start;
                on_stop_q    <= bus.on_stop;
                n_q          <= bus.n_periods;
                period_idx_q <= '0;
            end else if (advance) begin
                // Free-running mode (n_q == 0) lets the index wrap naturally.
                period_idx_q <= period_idx_q + NPER_ONE;
            end
        end
    end

    pulse_window_cmp #(
        .WIDTH(WIDTH)
    ) u_window (
        .clk      (clk),
        .reset    (reset),
        .count    (bus.count),
        .on_start (on_start_q),
        .on_stop  (on_stop_q),
        .en       (pulse_en),
        .pulse_out(bus.pulse_out)
    );

    assign bus.ctr_reset  = ctr_reset;
    assign bus.busy       = busy;
    assign bus.done       = done_q;
    assign bus.period_idx = period_idx_q;

endmodule
